vga_output_stage: RTL and testbench

VGA_OUTPUT_STAGE -- requirements
Module: vga_output_stage

---
 rtl/vga_output_stage_if.sv | 31 +++
 rtl/vga_output_stage.sv | 131 +++++++++++++
 tb/tb_vga_output_stage.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/vga_output_stage_if.sv
// Pixel stream between the renderer/sync generator and the VGA output stage.
// One pixel per clock, no flow control: every cycle carries a pixel, qualified by i_visible.
interface vga_output_stage_if #(
    parameter int OUT_BITS = 3
);
    logic                i_hsync;
    logic                i_vsync;
    logic                i_visible;
    logic [9:0]          i_hpos;
    logic [9:0]          i_vpos;
    logic [7:0]          i_r;
    logic [7:0]          i_g;
    logic [7:0]          i_b;
    logic                o_hsync;
    logic                o_vsync;
    logic                o_visible;
    logic                o_frame_odd;
    logic [OUT_BITS-1:0] o_r;
    logic [OUT_BITS-1:0] o_g;
    logic [OUT_BITS-1:0] o_b;

    modport master (
        output i_hsync, i_vsync, i_visible, i_hpos, i_vpos, i_r, i_g, i_b,
        input  o_hsync, o_vsync, o_visible, o_frame_odd, o_r, o_g, o_b
    );

    modport slave (
        input  i_hsync, i_vsync, i_visible, i_hpos, i_vpos, i_r, i_g, i_b,
        output o_hsync, o_vsync, o_visible, o_frame_odd, o_r, o_g, o_b
    );
endinterface

// File: rtl/vga_output_stage.sv
// VGA output stage: 2-cycle pipeline quantising 8-bit colour to OUT_BITS with
// 2x2 ordered dither (phase flipped every frame), saturation and sync polarity.
module vga_output_stage #(
    parameter int OUT_BITS        = 3,
    parameter int DITHER_EN       = 1,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    vga_output_stage_if.slave    vga
);
    localparam int SHIFT = 8 - OUT_BITS;

    // Stage 1: registered copies of the inputs
    logic       s1_hsync;
    logic       s1_vsync;
    logic       s1_visible;
    logic       s1_x;
    logic       s1_y;
    logic [7:0] s1_r;
    logic [7:0] s1_g;
    logic [7:0] s1_b;

    logic       prev_vsync;
    logic       parity;

    // Output register
    logic                q_hsync;
    logic                q_vsync;
    logic                q_visible;
    logic [OUT_BITS-1:0] q_r;
    logic [OUT_BITS-1:0] q_g;
    logic [OUT_BITS-1:0] q_b;

    // Stage 2 combinational results
    logic                vsync_rise;
    logic [1:0]          bayer;
    logic [8:0]          offset;
    logic [OUT_BITS-1:0] d_r;
    logic [OUT_BITS-1:0] d_g;
    logic [OUT_BITS-1:0] d_b;

    logic unused_pos_bits;
    assign unused_pos_bits = ^{vga.i_hpos[9:1], vga.i_vpos[9:1]};

    function automatic logic [OUT_BITS-1:0] quantise(input logic [7:0] c, input logic [8:0] off);
        logic [8:0] sum;
        logic [7:0] sat;
        sum = {1'b0, c} + off;
        sat = sum[8] ? 8'hff : sum[7:0];
        return sat[7 -: OUT_BITS];
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_hsync   <= 1'b0;
            s1_vsync   <= 1'b0;
            s1_visible <= 1'b0;
            s1_x       <= 1'b0;
            s1_y       <= 1'b0;
            s1_r       <= 8'd0;
            s1_g       <= 8'd0;
            s1_b       <= 8'd0;
            prev_vsync <= 1'b0;
            parity     <= 1'b0;
        end else begin
            s1_hsync   <= vga.i_hsync;
            s1_vsync   <= vga.i_vsync;
            s1_visible <= vga.i_visible;
            s1_x       <= vga.i_hpos[0];
            s1_y       <= vga.i_vpos[0];
            s1_r       <= vga.i_r;
            s1_g       <= vga.i_g;
            s1_b       <= vga.i_b;
            prev_vsync <= s1_vsync;
            if (vsync_rise) begin
                parity <= ~parity;
            end
        end
    end

    // The pixel sharing a cycle with the vsync edge still sees the old parity.
    always_comb begin
        vsync_rise = s1_vsync & ~prev_vsync;
        bayer      = 2'd0;
        offset     = 9'd0;
        d_r        = '0;
        d_g        = '0;
        d_b        = '0;
        case ({s1_y ^ parity, s1_x})
            2'b00:   bayer = 2'd0;
            2'b01:   bayer = 2'd2;
            2'b10:   bayer = 2'd3;
            default: bayer = 2'd1;
        endcase
        if (DITHER_EN != 0) begin
            offset = ({7'd0, bayer} << SHIFT) >> 2;
        end
        if (s1_visible) begin
            d_r = quantise(s1_r, offset);
            d_g = quantise(s1_g, offset);
            d_b = quantise(s1_b, offset);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            q_hsync   <= 1'b0;
            q_vsync   <= 1'b0;
            q_visible <= 1'b0;
            q_r       <= '0;
            q_g       <= '0;
            q_b       <= '0;
        end else begin
            q_hsync   <= s1_hsync;
            q_vsync   <= s1_vsync;
            q_visible <= s1_visible;
            q_r       <= d_r;
            q_g       <= d_g;
            q_b       <= d_b;
        end
    end

    assign vga.o_hsync     = (SYNC_ACTIVE_LOW != 0) ? ~q_hsync : q_hsync;
    assign vga.o_vsync     = (SYNC_ACTIVE_LOW != 0) ? ~q_vsync : q_vsync;
    assign vga.o_visible   = q_visible;
    assign vga.o_r         = q_r;
    assign vga.o_g         = q_g;
    assign vga.o_b         = q_b;
    assign vga.o_frame_odd = parity;
endmodule

// File: tb/tb_vga_output_stage.sv
// Directed bench for vga_output_stage with default parameters: driver pushes
// hand-computed expectations, a monitor compares them when they fall due.
module tb_vga_output_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vga_output_stage_if #(.OUT_BITS(3)) vga();

    vga_output_stage #(
        .OUT_BITS(3),
        .DITHER_EN(1),
        .SYNC_ACTIVE_LOW(1)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .vga(vga)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // entry = {due_cycle[15:0], hsync, vsync, visible, r[2:0], g[2:0], b[2:0]}
    logic [27:0] exp_q[$];
    logic [27:0] e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic hs, input logic vs, input logic vis,
                         input logic x, input logic y,
                         input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                         input logic ev, input logic [2:0] er, input logic [2:0] eg,
                         input logic [2:0] eb);
        @(negedge clk);
        vga.i_hsync   = hs;
        vga.i_vsync   = vs;
        vga.i_visible = vis;
        vga.i_hpos    = {9'd0, x};
        vga.i_vpos    = {9'd0, y};
        vga.i_r       = r;
        vga.i_g       = g;
        vga.i_b       = b;
        exp_q.push_back({16'(cyc + 2), ~hs, ~vs, ev, er, eg, eb});
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 3'd0, 3'd0, 3'd0);
    endtask

    // Monitor
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0 && exp_q[0][27:12] == 16'(cyc)) begin
            e = exp_q.pop_front();
            check("o_hsync",   16'(vga.o_hsync),   16'(e[11]));
            check("o_vsync",   16'(vga.o_vsync),   16'(e[10]));
            check("o_visible", 16'(vga.o_visible), 16'(e[9]));
            check("o_r",       16'(vga.o_r),       16'(e[8:6]));
            check("o_g",       16'(vga.o_g),       16'(e[5:3]));
            check("o_b",       16'(vga.o_b),       16'(e[2:0]));
        end
    end

    initial begin
        rst           = 1'b1;
        vga.i_hsync   = 1'b0;
        vga.i_vsync   = 1'b0;
        vga.i_visible = 1'b0;
        vga.i_hpos    = 10'd0;
        vga.i_vpos    = 10'd0;
        vga.i_r       = 8'd0;
        vga.i_g       = 8'd0;
        vga.i_b       = 8'd0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_o_r",         16'(vga.o_r),         16'd0);
        check("rst_o_g",         16'(vga.o_g),         16'd0);
        check("rst_o_b",         16'(vga.o_b),         16'd0);
        check("rst_o_visible",   16'(vga.o_visible),   16'd0);
        check("rst_o_frame_odd", 16'(vga.o_frame_odd), 16'd0);
        check("rst_o_hsync",     16'(vga.o_hsync),     16'd1);
        check("rst_o_vsync",     16'(vga.o_vsync),     16'd1);
        @(negedge clk);
        rst = 1'b0;

        // Parity 0, r=120 across the four Bayer phases
        drive(0, 0, 1, 0, 0, 8'd120, 8'd0, 8'd0, 1, 3'd3, 3'd0, 3'd0);
        drive(0, 0, 1, 1, 0, 8'd120, 8'd0, 8'd0, 1, 3'd4, 3'd0, 3'd0);
        drive(0, 0, 1, 0, 1, 8'd120, 8'd0, 8'd0, 1, 3'd4, 3'd0, 3'd0);
        drive(0, 0, 1, 1, 1, 8'd120, 8'd0, 8'd0, 1, 3'd4, 3'd0, 3'd0);

        // vsync held high for 10 cycles toggles parity once
        repeat (10) drive(0, 1, 0, 0, 0, 8'd0, 8'd0, 8'd0, 0, 3'd0, 3'd0, 3'd0);
        idle();
        @(posedge clk);
        #1;
        check("frame_odd_after_hold", 16'(vga.o_frame_odd), 16'd1);

        // Parity 1
        drive(0, 0, 1, 0, 0, 8'd120, 8'd223, 8'd0, 1, 3'd4, 3'd7, 3'd0);
        drive(0, 0, 1, 1, 0, 8'd120, 8'd223, 8'd0, 1, 3'd4, 3'd7, 3'd0);
        drive(0, 0, 1, 0, 1, 8'd120, 8'd223, 8'd0, 1, 3'd3, 3'd6, 3'd0);
        drive(0, 0, 1, 1, 1, 8'd120, 8'd223, 8'd0, 1, 3'd4, 3'd7, 3'd0);

        // Second pulse returns parity to 0
        drive(0, 1, 0, 0, 0, 8'd0, 8'd0, 8'd0, 0, 3'd0, 3'd0, 3'd0);
        idle();
        @(posedge clk);
        #1;
        check("frame_odd_second_pulse", 16'(vga.o_frame_odd), 16'd0);

        // Saturation and mid-range values at parity 0
        drive(0, 0, 1, 0, 1, 8'd0,  8'd250, 8'd255, 1, 3'd0, 3'd7, 3'd7);
        drive(0, 0, 1, 0, 0, 8'd31, 8'd223, 8'd255, 1, 3'd0, 3'd6, 3'd7);
        drive(0, 0, 1, 1, 0, 8'd31, 8'd200, 8'd255, 1, 3'd1, 3'd6, 3'd7);
        drive(0, 0, 1, 1, 1, 8'd31, 8'd239, 8'd255, 1, 3'd1, 3'd7, 3'd7);

        // Blanking forces black; hsync polarity
        drive(1, 0, 0, 0, 0, 8'd255, 8'd255, 8'd255, 0, 3'd0, 3'd0, 3'd0);
        drive(1, 0, 1, 1, 0, 8'd255, 8'd255, 8'd255, 1, 3'd7, 3'd7, 3'd7);
        idle();

        // Third pulse: parity 1 before the mid-stream reset
        drive(0, 1, 0, 0, 0, 8'd0, 8'd0, 8'd0, 0, 3'd0, 3'd0, 3'd0);
        idle();
        @(posedge clk);
        #1;
        check("frame_odd_third_pulse", 16'(vga.o_frame_odd), 16'd1);

        // Mid-stream reset: in-flight pixels are discarded, parity clears
        drive(0, 0, 1, 0, 0, 8'd200, 8'd0, 8'd0, 0, 3'd0, 3'd0, 3'd0);
        drive(0, 0, 1, 1, 0, 8'd200, 8'd0, 8'd0, 0, 3'd0, 3'd0, 3'd0);
        rst = 1'b1;
        drive(0, 0, 1, 0, 0, 8'd200, 8'd0, 8'd0, 1, 3'd6, 3'd0, 3'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("frame_odd_after_rst", 16'(vga.o_frame_odd), 16'd0);
        drive(0, 0, 1, 0, 1, 8'd200, 8'd0, 8'd0, 1, 3'd7, 3'd0, 3'd0);
        drive(0, 0, 1, 1, 1, 8'd200, 8'd0, 8'd0, 1, 3'd6, 3'd0, 3'd0);
        idle();

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
